// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller driving the BIST side of the memory mux, with read-compare pass/fail.
// Optional macro MBIST_DIAG_EN adds first-failure address/data capture and a mismatch counter.
module mbist_march_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  NbarT,
  output logic [ADDR_WIDTH-1:0] bist_addr,
  output logic [WIDTH-1:0]      bist_data,
  output logic                  bist_we,
  output logic                  bist_cs,
  input  logic [WIDTH-1:0]      mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  fail
`ifdef MBIST_DIAG_EN
  ,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0]      fail_data,
  output logic [15:0]           fail_count
`endif
);

  typedef enum logic [3:0] {
    StIdle, StM0, StM1, StM2, StM3, StM4, StM5, StDrain, StDone
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrLast = {ADDR_WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]      Ones     = {WIDTH{1'b1}};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    phase_q, phase_d;  // 0 = read half, 1 = write half of a two-op element

  logic                    start_ok;
  logic                    is_down, at_end;
  logic [ADDR_WIDTH-1:0]   addr_step;

  logic                    op_cs, op_we, op_act, op_done;
  logic [WIDTH-1:0]        op_data;

  logic                    rd_valid_q;
  logic [WIDTH-1:0]        rd_exp_q;
  logic                    mismatch;

  assign start_ok  = start && !busy && (state_q == StIdle || state_q == StDone);
  assign is_down   = (state_q == StM3) || (state_q == StM4);
  assign at_end    = is_down ? (addr_q == '0) : (addr_q == AddrLast);
  assign addr_step = is_down ? addr_q - 1'b1 : addr_q + 1'b1;
  assign mismatch  = rd_valid_q && (mem_q != rd_exp_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d = StM0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      StM0, StM5: begin
        if (at_end) begin
          state_d = (state_q == StM0) ? StM1 : StDrain;
          addr_d  = '0;
        end else begin
          addr_d = addr_step;
        end
      end
      StM1, StM2, StM3, StM4: begin
        phase_d = !phase_q;
        if (phase_q) begin
          if (at_end) begin
            unique case (state_q)
              StM1:    begin state_d = StM2; addr_d = '0;       end
              StM2:    begin state_d = StM3; addr_d = AddrLast; end
              StM3:    begin state_d = StM4; addr_d = AddrLast; end
              default: begin state_d = StM5; addr_d = '0;       end
            endcase
          end else begin
            addr_d = addr_step;
          end
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Operation decode; registered into the outputs so every BIST signal is glitch-free.
  always_comb begin
    op_cs   = 1'b0;
    op_we   = 1'b0;
    op_data = '0;
    op_done = 1'b0;
    case (state_q)
      StM0: begin
        op_cs = 1'b1;
        op_we = 1'b1;
      end
      StM1, StM3: begin
        op_cs   = 1'b1;
        op_we   = phase_q;
        op_data = phase_q ? Ones : '0;
      end
      StM2, StM4: begin
        op_cs   = 1'b1;
        op_we   = phase_q;
        op_data = phase_q ? '0 : Ones;
      end
      StM5:    op_cs = 1'b1;
      StDone:  op_done = 1'b1;
      default: ;
    endcase
    op_act = op_cs || (state_q == StDrain);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      phase_q    <= 1'b0;
      NbarT      <= 1'b0;
      bist_addr  <= '0;
      bist_data  <= '0;
      bist_we    <= 1'b0;
      bist_cs    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_exp_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      phase_q    <= phase_d;
      NbarT      <= op_act;
      bist_addr  <= op_cs ? addr_q : '0;
      bist_data  <= op_data;
      bist_we    <= op_we;
      bist_cs    <= op_cs;
      busy       <= op_act;
      done       <= op_done && !start_ok;
      // Read on the bus now; its data returns next cycle and is checked then.
      rd_valid_q <= bist_cs && !bist_we;
      rd_exp_q   <= bist_data;
      if (start_ok)      fail <= 1'b0;
      else if (mismatch) fail <= 1'b1;
    end
  end

`ifdef MBIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_q  <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_count <= '0;
    end else begin
      rd_addr_q <= bist_addr;
      if (start_ok) begin
        fail_addr  <= '0;
        fail_data  <= '0;
        fail_count <= '0;
      end else if (mismatch) begin
        if (!fail) begin
          fail_addr <= rd_addr_q;
          fail_data <= mem_q;
        end
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: a driver queues expected trace points and run
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_mbist_march_ctrl;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          NbarT, bist_we, bist_cs, busy, done, fail;
  logic [AW-1:0] bist_addr;
  logic [W-1:0]  bist_data;
  logic [W-1:0]  mem_q = '0;
`ifdef MBIST_DIAG_EN
  logic [AW-1:0] fail_addr;
  logic [W-1:0]  fail_data;
  logic [15:0]   fail_count;
`endif

  always #5 clk = ~clk;

  mbist_march_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .NbarT     (NbarT),
    .bist_addr (bist_addr),
    .bist_data (bist_data),
    .bist_we   (bist_we),
    .bist_cs   (bist_cs),
    .mem_q     (mem_q),
    .busy      (busy),
    .done      (done),
    .fail      (fail)
`ifdef MBIST_DIAG_EN
    ,
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_count(fail_count)
`endif
  );

  // Single-port SRAM model with an optional stuck-at-0 on bit 3 of word 5.
  logic [W-1:0] mem [N];
  logic         fault_en = 1'b0;
  always @(posedge clk) begin
    if (NbarT && bist_cs) begin
      if (bist_we) mem[bist_addr] <= bist_data;
      else mem_q <= (fault_en && bist_addr == 4'd5) ? (mem[bist_addr] & 8'hF7) : mem[bist_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic         nbart;
    logic [AW-1:0] addr;
    logic [W-1:0] data;
    logic         chk_ad;
    logic         we, cs, busy, done, fail;
  } trace_t;

  typedef struct {
    int           cyc;
    logic         fail;
    logic [AW-1:0] faddr;
    logic [W-1:0] fdata;
    logic [15:0]  fcnt;
  } result_t;

  trace_t  trace_q[$];
  result_t result_q[$];
  int      n_vec = 0;
  int      n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic trace_t mk(input int c, input logic nb, input logic [AW-1:0] a,
                                input logic [W-1:0] d, input logic cad, input logic we,
                                input logic cs, input logic bz, input logic dn, input logic f);
    trace_t t;
    t.cyc = c; t.nbart = nb; t.addr = a; t.data = d; t.chk_ad = cad;
    t.we = we; t.cs = cs; t.busy = bz; t.done = dn; t.fail = f;
    return t;
  endfunction

  // Monitor
  int   nb_cnt = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin : monitor
    trace_t  t;
    result_t r;
    if (!rst_n) nb_cnt = 0;
    else if (NbarT) nb_cnt++;
    if (trace_q.size() > 0 && trace_q[0].cyc == cyc) begin
      t = trace_q.pop_front();
      check("NbarT", NbarT, t.nbart);
      check("bist_cs", bist_cs, t.cs);
      check("bist_we", bist_we, t.we);
      check("busy", busy, t.busy);
      check("done", done, t.done);
      check("fail", fail, t.fail);
      if (t.chk_ad) begin
        check("bist_addr", bist_addr, t.addr);
        check("bist_data", bist_data, t.data);
      end
    end
    if (done && !done_prev) begin
      if (result_q.size() == 0) begin
        check("done_unexpected", done, 1'b0);
      end else begin
        r = result_q.pop_front();
        check("done_cycle", cyc, r.cyc);
        check("result_fail", fail, r.fail);
        check("nbart_cycles", nb_cnt, 161);
`ifdef MBIST_DIAG_EN
        check("fail_addr", fail_addr, r.faddr);
        check("fail_data", fail_data, r.fdata);
        check("fail_count", fail_count, r.fcnt);
`endif
      end
      nb_cnt = 0;
    end
    done_prev = done;
  end

  task automatic wait_result();
    int guard = 0;
    while (result_q.size() > 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    if (result_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: no done within 400 cycles, %0d results pending", result_q.size());
      result_q.delete();
      trace_q.delete();
    end
  endtask

  task automatic pulse_start(output int e0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e0 = cyc;
  endtask

  // One full run; expected trace points are offsets from the start-sampling edge.
  task automatic run(input bit faulty, input bit retrigger);
    int      e0;
    result_t r;
    fault_en = faulty;
    pulse_start(e0);
    trace_q.push_back(mk(e0 + 1,   1, 4'd0,  8'h00, 1, 1, 1, 1, 0, 0));
    trace_q.push_back(mk(e0 + 16,  1, 4'd15, 8'h00, 1, 1, 1, 1, 0, 0));
    trace_q.push_back(mk(e0 + 17,  1, 4'd0,  8'h00, 1, 0, 1, 1, 0, 0));
    trace_q.push_back(mk(e0 + 18,  1, 4'd0,  8'hFF, 1, 1, 1, 1, 0, 0));
    trace_q.push_back(mk(e0 + 81,  1, 4'd15, 8'h00, 1, 0, 1, 1, 0, faulty));
    trace_q.push_back(mk(e0 + 82,  1, 4'd15, 8'hFF, 1, 1, 1, 1, 0, faulty));
    trace_q.push_back(mk(e0 + 112, 1, 4'd0,  8'hFF, 1, 1, 1, 1, 0, faulty));
    trace_q.push_back(mk(e0 + 113, 1, 4'd15, 8'hFF, 1, 0, 1, 1, 0, faulty));
    trace_q.push_back(mk(e0 + 145, 1, 4'd0,  8'h00, 1, 0, 1, 1, 0, faulty));
    trace_q.push_back(mk(e0 + 160, 1, 4'd15, 8'h00, 1, 0, 1, 1, 0, faulty));
    trace_q.push_back(mk(e0 + 161, 1, 4'd0,  8'h00, 0, 0, 0, 1, 0, faulty));
    r.cyc   = e0 + 162;
    r.fail  = faulty;
    r.faddr = faulty ? 4'd5 : 4'd0;
    r.fdata = faulty ? 8'hF7 : 8'h00;
    r.fcnt  = faulty ? 16'd2 : 16'd0;
    result_q.push_back(r);
    if (retrigger) begin
      while (cyc < e0 + 60) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_result();
  endtask

  initial begin : driver
    int e0;
    repeat (3) @(posedge clk);
    #1;
    trace_q.push_back(mk(cyc, 0, 4'd0, 8'h00, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(1'b0, 1'b0);
    run(1'b1, 1'b0);
    run(1'b0, 1'b0);

    // Abort during M3 with a one-cycle reset.
    fault_en = 1'b0;
    pulse_start(e0);
    while (cyc < e0 + 90) @(posedge clk);
    #1 rst_n = 1'b0;
    trace_q.push_back(mk(cyc + 1, 0, 4'd0, 8'h00, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run(1'b0, 1'b0);
    run(1'b0, 1'b1);

    repeat (4) @(posedge clk);
    if (trace_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL trace_pending: %0d trace points never reached", trace_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Upstream MBIST engine for the BIST/normal multiplexer.
- Runs a March C- test on a single-port synchronous SRAM and drives the BIST-side address, data and write-enable.
- Drives the NbarT select that steers the mux from normal traffic to BIST traffic.
- Compares read data against expected values and reports pass/fail.

Parameters:
- WIDTH, 8, memory data width in bits.
- ADDR_WIDTH, 4, memory address width; depth N = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a test; sampled only in IDLE or DONE.
- NbarT  output  1  mux select; 1 = BIST owns memory, 0 = normal path.
- bist_addr  output  ADDR_WIDTH  BIST address to mux.
- bist_data  output  WIDTH  BIST write data to mux.
- bist_we  output  1  BIST write enable; 1 = write, 0 = read.
- bist_cs  output  1  BIST chip select; 1 on every March operation cycle.
- mem_q  input  WIDTH  memory read data, valid one cycle after a read is issued.
- busy  output  1  test in progress.
- done  output  1  test complete; level, held until next start or reset.
- fail  output  1  sticky mismatch flag, cleared on start.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE. All of NbarT, bist_addr, bist_data, bist_we, bist_cs, busy, done and fail go to 0. The compare pipeline is cleared.
- Reset mid-test aborts the run immediately, with outputs as above on the next cycle.
- States: IDLE, M0..M5, DRAIN, DONE.
- March C- elements, one operation per cycle, no gaps:
  - M0: up, w0.
  - M1: up, r0 then w1.
  - M2: up, r1 then w0.
  - M3: down, r0 then w1.
  - M4: down, r1 then w0.
  - M5: up, r0.
- Data patterns: "0" = all zeros, "1" = all ones (WIDTH bits).
- Within each address, a two-op element issues the read cycle first, then the write cycle at the same address.
- Address order: up = 0 to N-1; down = N-1 to 0. On the last address, step to the next element's start address with no idle cycle.
- start sampled in IDLE or DONE: the next state is M0 and fail/done are cleared. The first operation is driven the cycle after start is sampled. start is ignored while busy=1.
- NbarT, busy and bist_cs are 1 in M0..M5. In DRAIN, NbarT=1, busy=1, bist_cs=0. In IDLE and DONE, all three are 0.
- Compare pipeline: each read cycle registers the expected value and a valid bit. On the following cycle, mem_q is compared against the expected value when valid=1. A mismatch sets fail.
- After the final M5 read, go to DRAIN for one cycle so the last compare completes, then go to DONE.
- Latency: if start is sampled at edge E0, operations occupy cycles 1..10N, DRAIN is cycle 10N+1, and done=1 from edge E0+10N+2.
- In DONE: done=1 and fail holds its result. A new start restarts from M0.
- Simultaneous start and rst_n=0: reset wins.

Optional Feature:
- Macro: MBIST_DIAG_EN.
- Defined: adds the following outputs.
  - fail_addr [ADDR_WIDTH-1:0]: address of the first mismatch, captured once per run.
  - fail_data [WIDTH-1:0]: mem_q at the first mismatch.
  - fail_count [15:0]: number of mismatching reads, saturating at 16'hFFFF.
  - All three reset to 0 and are cleared on start.
- Not defined: these ports and registers do not exist. fail is the only result.

Test Plan:
1. Fault-free memory, WIDTH=8, ADDR_WIDTH=4 (N=16); pulse start → done rises exactly 162 cycles after the start-sampling edge, fail=0, and NbarT=1 for cycles 1..161.
2. Trace check, fault-free: cycle 1 is addr 0, we=1, data 8'h00; M1 first pair is addr 0 read then addr 0 write 8'hFF; first M3 read is at addr 15.
3. Stuck-at-0 on bit 3 at addr 5 → fail=1 at done. With MBIST_DIAG_EN: fail_addr=5, fail_data=8'hF7, fail_count=2 (M2 and M4 r1 reads).
4. Assert rst_n=0 for one cycle during M3 → next cycle NbarT=0, busy=0, done=0, fail=0, bist_cs=0; a new start gives a full clean run.
5. Pulse start again while busy, mid-M2 → ignored; done still arrives at the original 162-cycle point.
6. After a failing run, start with a fault-free memory → fail cleared on start, 0 at the new done.
